// File: rtl/fpaddsub_sched_pkg.sv
// Shared types and constants for the FP add/sub scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpaddsub_sched_pkg;

    localparam int N_DEF     = 4;
    localparam int LAT_DEF   = 11;
    localparam int DEPTH_DEF = 4;

    // Bit positions inside the 5-bit flag word
    localparam int OVF = 4;
    localparam int UNF = 3;
    localparam int DZ  = 2;
    localparam int INV = 1;
    localparam int INX = 0;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    typedef struct packed {
        logic [4:0]  flags;
        logic [31:0] z;
    } rsp_t;

endpackage

// File: rtl/fpaddsub_rsp_fifo.sv
// Per-requester response FIFO (DEPTH x rsp_t) with an occupancy count.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: none on push (space is reserved upstream); pop is ignored when empty.
module fpaddsub_rsp_fifo
    import fpaddsub_sched_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  rsp_t                     push_dat,
    input  logic                     pop,
    output rsp_t                     head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    rsp_t          mem_q [DEPTH];
    rsp_t          mem_d [DEPTH];
    logic          do_pop;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_pop   = pop && (cnt_q != '0);
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !do_pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (!push && do_pop) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    // Pointer and count registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: an empty FIFO masks its head to zero
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // A push into a full FIFO means the upstream credit accounting is broken
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            assert (cnt_q != (AW+1)'(DEPTH));
        end
    end

    assign head  = (cnt_q == '0) ? rsp_t'(0) : mem_q[rd_ptr_q];
    assign count = cnt_q;

endmodule

// File: rtl/fpaddsub_sched.sv
// Round-robin, credit-gated scheduler sharing one pipelined FP add/sub among N requesters.
// Latency: issue is combinational; a result is pushed LAT edges after its issue edge.
// Backpressure: a requester is only granted while it holds a credit (free response slot).
module fpaddsub_sched
    import fpaddsub_sched_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LAT   = LAT_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [32*N-1:0]   req_a,
    input  logic [32*N-1:0]   req_b,
    input  logic [N-1:0]      req_op,
    output logic [N-1:0]      rsp_valid,
    input  logic [N-1:0]      rsp_ready,
    output logic [32*N-1:0]   rsp_z,
    output logic [5*N-1:0]    rsp_flags,
    output logic [31:0]       fp_a,
    output logic [31:0]       fp_b,
    output logic              fp_ctrl,
    input  logic [31:0]       fp_z,
    input  logic [4:0]        fp_flags
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [IW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]  inflight_q [N];
    logic [CW-1:0]  inflight_d [N];
    logic [LAT-1:0] tv_q, tv_d;
    logic [IW-1:0]  tid_q [LAT];
    logic [IW-1:0]  tid_d [LAT];
    logic [CW-1:0]  fifo_cnt [N];
    rsp_t           fifo_head [N];
    logic [N-1:0]   elig;
    logic [2*N-1:0] elig_dbl;
    logic [N-1:0]   elig_rot;
    logic           gnt_vld;
    logic [IW:0]    gnt_sum, ptr_nxt;
    logic [IW-1:0]  gnt_id;
    logic           ret_vld;
    logic [IW-1:0]  ret_id;

    assign ret_vld = tv_q[LAT-1];
    assign ret_id  = tid_q[LAT-1];

    // A requester is eligible while queued plus in-flight results leave a free slot
    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = req_valid[i] &&
                      (({1'b0, fifo_cnt[i]} + {1'b0, inflight_q[i]}) < (CW+1)'(DEPTH));
        end
    end

    // Round-robin pick: rotate eligibility so ptr sits at bit 0, take the lowest set bit
    always_comb begin
        elig_dbl  = {elig, elig};
        elig_rot  = elig_dbl[ptr_q +: N];
        gnt_vld   = 1'b0;
        gnt_sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                gnt_vld = 1'b1;
                gnt_sum = {1'b0, ptr_q} + (IW+1)'(k);
            end
        end
        if (gnt_sum >= (IW+1)'(N)) begin
            gnt_sum = gnt_sum - (IW+1)'(N);
        end
        gnt_id  = gnt_sum[IW-1:0];
        ptr_nxt = gnt_sum + (IW+1)'(1);
        if (ptr_nxt == (IW+1)'(N)) begin
            ptr_nxt = '0;
        end
        ptr_d     = gnt_vld ? ptr_nxt[IW-1:0] : ptr_q;
        req_ready = '0;
        if (gnt_vld) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    // Operand mux toward the FP unit; idle cycles drive zeros
    always_comb begin
        fp_a    = '0;
        fp_b    = '0;
        fp_ctrl = ADD;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                fp_a    = req_a[32*i +: 32];
                fp_b    = req_b[32*i +: 32];
                fp_ctrl = req_op[i];
            end
        end
    end

    // In-flight accounting: +1 on issue, -1 on retire, unchanged when both hit one requester
    always_comb begin
        for (int i = 0; i < N; i++) begin
            inflight_d[i] = inflight_q[i];
            case ({gnt_vld && (gnt_id == IW'(i)), ret_vld && (ret_id == IW'(i))})
                2'b10:   inflight_d[i] = inflight_q[i] + CW'(1);
                2'b01:   inflight_d[i] = inflight_q[i] - CW'(1);
                default: inflight_d[i] = inflight_q[i];
            endcase
        end
    end

    // Tag pipeline mirrors the FP unit depth so the owner is known when fp_z is valid
    always_comb begin
        tv_d     = {tv_q[LAT-2:0], gnt_vld};
        tid_d[0] = gnt_id;
        for (int s = 1; s < LAT; s++) begin
            tid_d[s] = tid_q[s-1];
        end
    end

    // Control state; reset drops every in-flight tag so stale results are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            tv_q  <= '0;
            for (int i = 0; i < N; i++) begin
                inflight_q[i] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            tv_q       <= tv_d;
            inflight_q <= inflight_d;
        end
    end

    // Tag IDs are qualified by tv, so they carry no reset
    always_ff @(posedge clk) begin
        tid_q <= tid_d;
    end

    for (genvar g = 0; g < N; g++) begin : g_rsp
        fpaddsub_rsp_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (ret_vld && (ret_id == IW'(g))),
            .push_dat ({fp_flags, fp_z}),
            .pop      (rsp_ready[g]),
            .head     (fifo_head[g]),
            .count    (fifo_cnt[g])
        );
        assign rsp_valid[g]          = (fifo_cnt[g] != '0);
        assign rsp_z[32*g +: 32]     = fifo_head[g].z;
        assign rsp_flags[5*g +: 5]   = fifo_head[g].flags;
    end

endmodule

// File: tb/tb_fpaddsub_sched.sv
// Directed bench for fpaddsub_sched with a behavioural LAT-deep FP unit model.
// Latency: n/a.
// Backpressure: driven per phase through rsp_ready.
module tb_fpaddsub_sched;
    import fpaddsub_sched_pkg::*;

    localparam int N     = 4;
    localparam int LAT   = 11;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_a;
    logic [32*N-1:0]   req_b;
    logic [N-1:0]      req_op;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_ready;
    logic [32*N-1:0]   rsp_z;
    logic [5*N-1:0]    rsp_flags;
    logic [31:0]       fp_a, fp_b, fp_z;
    logic              fp_ctrl;
    logic [4:0]        fp_flags;

    int checks = 0;
    int errors = 0;
    int gnt_cnt [N];
    int pop_cnt [N];
    int cur_gnt;
    int seq = 0;
    logic [36:0] exp_q [N][$];
    logic [36:0] fpm_q [LAT];

    fpaddsub_sched #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_flags (rsp_flags),
        .fp_a      (fp_a),
        .fp_b      (fp_b),
        .fp_ctrl   (fp_ctrl),
        .fp_z      (fp_z),
        .fp_flags  (fp_flags)
    );

    always #5 clk = ~clk;

    // Known IEEE vectors are exact; anything else gets a cheap unique stand-in
    function automatic logic [36:0] fp_ref(input logic [31:0] a, input logic [31:0] b, input logic op);
        if (a == 32'h3F800000 && b == 32'h40000000 && op == ADD) return {5'b0, 32'h40400000};
        if (a == 32'h40400000 && b == 32'h3F800000 && op == SUB) return {5'b0, 32'h40000000};
        return {a[4:0] ^ b[9:5], (op == SUB) ? (a - b) : (a + b)};
    endfunction

    // FP unit model: sampled at edge t, result held for sampling at edge t+LAT; never reset
    always @(posedge clk) begin
        fpm_q[0] <= fp_ref(fp_a, fp_b, fp_ctrl);
        for (int s = 1; s < LAT; s++) fpm_q[s] <= fpm_q[s-1];
    end
    assign fp_flags = fpm_q[LAT-1][36:32];
    assign fp_z     = fpm_q[LAT-1][31:0];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_counts();
        for (int i = 0; i < N; i++) begin
            gnt_cnt[i] = 0;
            pop_cnt[i] = 0;
        end
    endtask

    task automatic set_ops(input int s);
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = {8'(i), 24'(s)};
            req_b[32*i +: 32] = {8'hA5, 24'(s * 4 + i)};
            req_op[i]         = 1'(s + i);
        end
    endtask

    // Settle, observe what the coming edge will do, then advance to the next negedge
    task automatic tick();
        #1;
        cur_gnt = -1;
        chk("gnt_onehot", 64'($onehot0(req_ready)), 64'd1);
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                chk("fp_a_mux", fp_a, req_a[32*i +: 32]);
                chk("fp_ctrl_mux", fp_ctrl, req_op[i]);
                exp_q[i].push_back(fp_ref(req_a[32*i +: 32], req_b[32*i +: 32], req_op[i]));
                gnt_cnt[i]++;
                cur_gnt = i;
            end
            if (rsp_valid[i] && rsp_ready[i]) begin
                pop_cnt[i]++;
                if (exp_q[i].size() == 0) chk("rsp_unexpected", rsp_valid[i], 1'b0);
                else chk("rsp_dat", {rsp_flags[5*i +: 5], rsp_z[32*i +: 32]}, exp_q[i].pop_front());
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int left;
        left = 0;
        for (int k = 0; k < 300; k++) begin
            left = 0;
            for (int i = 0; i < N; i++) left += exp_q[i].size();
            if (left == 0) break;
            tick();
        end
        chk(tag, left, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) exp_q[i].delete();
    endtask

    initial begin
        #500000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        int j;
        logic [N-1:0] oth;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        rsp_ready = '0;
        clr_counts();
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_z_lo", rsp_z[63:0], 0);
        chk("rst_rsp_z_hi", rsp_z[127:64], 0);
        chk("rst_rsp_flags", rsp_flags, 0);
        chk("rst_fp_a", fp_a, 0);
        chk("rst_fp_b", fp_b, 0);
        chk("rst_fp_ctrl", fp_ctrl, 0);
        rst = 1'b0;
        rsp_ready = '1;

        // Single add on requester 0: 1.0 + 2.0 = 3.0
        req_a[31:0] = 32'h3F800000;
        req_b[31:0] = 32'h40000000;
        req_op[0]   = ADD;
        req_valid   = 4'b0001;
        #1;
        chk("single_rdy", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        j = 0;
        while (!rsp_valid[0] && j < 3 * LAT) begin
            tick();
            j++;
        end
        chk("single_lat", j, LAT);
        chk("single_z", rsp_z[31:0], 32'h40400000);
        chk("single_flags", rsp_flags[4:0], 0);
        tick();
        chk("single_popped", rsp_valid, 0);

        // Subtract routed to requester 2: 3.0 - 1.0 = 2.0
        req_a[95:64] = 32'h40400000;
        req_b[95:64] = 32'h3F800000;
        req_op[2]    = SUB;
        req_valid    = 4'b0100;
        #1;
        chk("sub_rdy", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        j = 0;
        oth = '0;
        while (!rsp_valid[2] && j < 3 * LAT) begin
            oth |= rsp_valid & 4'b1011;
            tick();
            j++;
        end
        chk("sub_lat", j, LAT);
        chk("sub_z", rsp_z[95:64], 32'h40000000);
        chk("sub_flags", rsp_flags[14:10], 0);
        chk("sub_other_vld", oth | (rsp_valid & 4'b1011), 0);
        chk("sub_slot0_empty", rsp_z[31:0], 0);
        drain("sub_drain");

        // Fairness: all requesters busy, ptr is 3 after granting requester 2
        clr_counts();
        req_valid = '1;
        j = 3;
        for (int c = 0; c < 400; c++) begin
            set_ops(seq);
            seq++;
            tick();
            chk("rr_order", cur_gnt, j);
            j = (j + 1) % N;
        end
        for (int i = 0; i < N; i++) chk("rr_share", gnt_cnt[i], 100);
        req_valid = '0;
        drain("rr_drain");

        // Backpressure on requester 1
        clr_counts();
        rsp_ready = 4'b1101;
        req_valid = '1;
        for (int c = 0; c < 60; c++) begin
            set_ops(seq);
            seq++;
            tick();
        end
        chk("bp_gnt1", gnt_cnt[1], DEPTH);
        chk("bp_rdy1_low", req_ready[1], 1'b0);
        chk("bp_rsp1_vld", rsp_valid[1], 1'b1);
        chk("bp_others", (gnt_cnt[0] >= 15) && (gnt_cnt[2] >= 15) && (gnt_cnt[3] >= 15), 1'b1);
        req_valid = '0;
        rsp_ready = '1;
        clr_counts();
        drain("bp_drain");
        chk("bp_pop1", pop_cnt[1], DEPTH);

        // Reset with five ops in flight: nothing may come back
        req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            set_ops(seq);
            seq++;
            tick();
        end
        pulse_reset();
        chk("mid_rst_rdy", req_ready, 0);
        oth = '0;
        for (int c = 0; c < 2 * LAT; c++) begin
            oth |= rsp_valid;
            tick();
        end
        chk("mid_rst_no_rsp", oth, 0);

        // Full credits after reset, ptr restarts at 0
        clr_counts();
        rsp_ready = '0;
        req_valid = '1;
        for (int c = 0; c < 24; c++) begin
            set_ops(seq);
            seq++;
            tick();
            if (c == 0) chk("mid_rst_ptr", cur_gnt, 0);
        end
        for (int i = 0; i < N; i++) chk("mid_rst_credits", gnt_cnt[i], DEPTH);
        req_valid = '0;
        rsp_ready = '1;
        drain("mid_rst_drain");

        // Single requester at its credit limit: same-edge push/pop and issue/retire
        clr_counts();
        req_valid = 4'b1000;
        for (int c = 0; c < 40; c++) begin
            set_ops(seq);
            seq++;
            tick();
            if (c == 12) chk("conc_first_window", gnt_cnt[3], 4);
        end
        chk("conc_gnt", gnt_cnt[3], 13);
        req_valid = '0;
        drain("conc_drain");
        chk("conc_pop", pop_cnt[3], 13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
